fb_id_stage: RTL and testbench

- Instruction-decode stage of the five-stage RV32I pipeline.
- Accepts fetched instructions from IF over a valid/ready handshake and decodes them.
- Drives the register-file read addresses and applies a same-cycle writeback bypass to the read data.
- Registers the decoded operation into the ID/EX pipeline register.
- Detects load-use hazards, inserts bubbles, and honours pipeline flush.

---
 rtl/fb_id_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_fb_id_stage.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_id_stage.sv
// Instruction-decode stage of the five-stage RV32I pipeline: decodes the IF word,
// reads/bypasses operands, detects load-use hazards and fills the ID/EX register.
module fb_id_stage #(
  parameter bit RESET_PC_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic        ex_rd_we,
  output logic [3:0]  ex_alu_op,
  output logic [3:0]  ex_opclass,
  output logic        ex_illegal
);

  localparam int DATA_W = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] CLS_NONE   = 4'b0000;
  localparam logic [3:0] CLS_ALU    = 4'b0001;
  localparam logic [3:0] CLS_LOAD   = 4'b0010;
  localparam logic [3:0] CLS_STORE  = 4'b0100;
  localparam logic [3:0] CLS_BRANCH = 4'b1000;
  localparam logic [3:0] ALU_ADD    = 4'b0000;

  // Writeback data written this cycle is not yet visible in the register file.
  function automatic logic [DATA_W-1:0] bypass(
    input logic [4:0]        rs,
    input logic [DATA_W-1:0] rf_data,
    input logic              we,
    input logic [4:0]        waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (rs == 5'd0)
      return '0;
    else if (we && (waddr == rs))
      return wdata;
    else
      return rf_data;
  endfunction

  logic [6:0]               opcode_p0;
  logic [2:0]               funct3_p0;
  logic [4:0]               rs1_p0;
  logic [4:0]               rs2_p0;
  logic [4:0]               rd_p0;
  logic signed [DATA_W-1:0] imm_p0;
  logic                     uses_rs1_p0;
  logic                     uses_rs2_p0;
  logic [3:0]               cls_p0;
  logic                     rd_we_dec_p0;
  logic                     rd_we_p0;
  logic [3:0]               alu_op_p0;
  logic                     illegal_p0;
  logic [DATA_W-1:0]        rs1_val_p0;
  logic [DATA_W-1:0]        rs2_val_p0;

  logic                     vld_p1;
  logic [DATA_W-1:0]        pc_p1;
  logic [DATA_W-1:0]        rs1_val_p1;
  logic [DATA_W-1:0]        rs2_val_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [4:0]               rd_p1;
  logic                     rd_we_p1;
  logic [3:0]               alu_op_p1;
  logic [3:0]               cls_p1;
  logic                     illegal_p1;

  logic advance;
  logic hazard;

  // ---- stage p0: decode of the IF word ----
  assign opcode_p0 = if_inst[6:0];
  assign funct3_p0 = if_inst[14:12];
  assign rd_p0     = if_inst[11:7];
  assign rs1_p0    = if_inst[19:15];
  assign rs2_p0    = if_inst[24:20];

  assign rf_raddr1 = rs1_p0;
  assign rf_raddr2 = rs2_p0;

  always_comb begin
    imm_p0       = '0;
    uses_rs1_p0  = 1'b0;
    uses_rs2_p0  = 1'b0;
    cls_p0       = CLS_NONE;
    rd_we_dec_p0 = 1'b0;
    alu_op_p0    = ALU_ADD;
    illegal_p0   = 1'b0;
    case (opcode_p0)
      OPC_LUI, OPC_AUIPC: begin
        imm_p0       = $signed({if_inst[31:12], 12'b0});
        cls_p0       = CLS_ALU;
        rd_we_dec_p0 = 1'b1;
      end
      OPC_JAL: begin
        imm_p0       = $signed({{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                                if_inst[20], if_inst[30:21], 1'b0});
        cls_p0       = CLS_BRANCH;
        rd_we_dec_p0 = 1'b1;
        alu_op_p0    = {1'b0, funct3_p0};
      end
      OPC_JALR: begin
        imm_p0       = $signed({{20{if_inst[31]}}, if_inst[31:20]});
        uses_rs1_p0  = 1'b1;
        cls_p0       = CLS_BRANCH;
        rd_we_dec_p0 = 1'b1;
        alu_op_p0    = {1'b0, funct3_p0};
      end
      OPC_BRANCH: begin
        imm_p0       = $signed({{19{if_inst[31]}}, if_inst[31], if_inst[7],
                                if_inst[30:25], if_inst[11:8], 1'b0});
        uses_rs1_p0  = 1'b1;
        uses_rs2_p0  = 1'b1;
        cls_p0       = CLS_BRANCH;
        alu_op_p0    = {1'b0, funct3_p0};
      end
      OPC_LOAD: begin
        imm_p0       = $signed({{20{if_inst[31]}}, if_inst[31:20]});
        uses_rs1_p0  = 1'b1;
        cls_p0       = CLS_LOAD;
        rd_we_dec_p0 = 1'b1;
      end
      OPC_STORE: begin
        imm_p0       = $signed({{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]});
        uses_rs1_p0  = 1'b1;
        uses_rs2_p0  = 1'b1;
        cls_p0       = CLS_STORE;
      end
      OPC_OPIMM: begin
        imm_p0       = $signed({{20{if_inst[31]}}, if_inst[31:20]});
        uses_rs1_p0  = 1'b1;
        cls_p0       = CLS_ALU;
        rd_we_dec_p0 = 1'b1;
        // Only the shift-right pair uses inst[30] as an opcode bit; elsewhere it is imm.
        alu_op_p0    = {(funct3_p0 == 3'b101) ? if_inst[30] : 1'b0, funct3_p0};
      end
      OPC_OP: begin
        uses_rs1_p0  = 1'b1;
        uses_rs2_p0  = 1'b1;
        cls_p0       = CLS_ALU;
        rd_we_dec_p0 = 1'b1;
        alu_op_p0    = {if_inst[30], funct3_p0};
      end
      default: begin
        illegal_p0   = 1'b1;
      end
    endcase
  end

  assign rd_we_p0   = rd_we_dec_p0 && (rd_p0 != 5'd0);
  assign rs1_val_p0 = bypass(rs1_p0, rf_rdata1, wb_we, wb_waddr, wb_wdata);
  assign rs2_val_p0 = bypass(rs2_p0, rf_rdata2, wb_we, wb_waddr, wb_wdata);

  // A load in ID/EX cannot forward in time to a dependent instruction behind it.
  assign advance  = !vld_p1 || ex_ready;
  assign hazard   = if_valid && vld_p1 && cls_p1[1] && (rd_p1 != 5'd0) &&
                    ((uses_rs1_p0 && (rs1_p0 == rd_p1)) ||
                     (uses_rs2_p0 && (rs2_p0 == rd_p1)));
  assign if_ready = flush || (advance && !hazard);

  // ---- stage p1: ID/EX register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1     <= 1'b0;
      pc_p1      <= '0;
      rs1_val_p1 <= '0;
      rs2_val_p1 <= '0;
      imm_p1     <= '0;
      rd_p1      <= '0;
      rd_we_p1   <= 1'b0;
      alu_op_p1  <= '0;
      cls_p1     <= '0;
      illegal_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      if (RESET_PC_ZERO) pc_p1 <= '0;
    end else if (advance) begin
      if (!hazard && if_valid) begin
        vld_p1     <= 1'b1;
        pc_p1      <= if_pc;
        rs1_val_p1 <= rs1_val_p0;
        rs2_val_p1 <= rs2_val_p0;
        imm_p1     <= imm_p0;
        rd_p1      <= rd_p0;
        rd_we_p1   <= rd_we_p0;
        alu_op_p1  <= alu_op_p0;
        cls_p1     <= cls_p0;
        illegal_p1 <= illegal_p0;
      end else begin
        vld_p1 <= 1'b0;
        if (RESET_PC_ZERO) pc_p1 <= '0;
      end
    end
  end

  assign ex_valid   = vld_p1;
  assign ex_pc      = pc_p1;
  assign ex_rs1_val = rs1_val_p1;
  assign ex_rs2_val = rs2_val_p1;
  assign ex_imm     = imm_p1;
  assign ex_rd      = rd_p1;
  assign ex_rd_we   = rd_we_p1;
  assign ex_alu_op  = alu_op_p1;
  assign ex_opclass = cls_p1;
  assign ex_illegal = illegal_p1;

endmodule

// File: tb/tb_fb_id_stage.sv
// Testbench for fb_id_stage: directed scenarios plus randomized traffic checked
// against an instruction-level reference model of the ID/EX register.
module tb_fb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;
  logic [3:0]  ex_alu_op;
  logic [3:0]  ex_opclass;
  logic        ex_illegal;

  always #5 clk = ~clk;

  fb_id_stage #(.RESET_PC_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_alu_op(ex_alu_op),
    .ex_opclass(ex_opclass), .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rd_we;
    logic [3:0]  alu;
    logic [3:0]  cls;
    logic        ill;
  } exp_t;

  exp_t m;
  int   n_checks = 0;
  int   n_pass = 0;
  logic rdy_obs;
  logic rdy_exp;

  logic [6:0] ops [0:9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h00};

  function automatic exp_t observe();
    exp_t o;
    o.valid = ex_valid;  o.pc = ex_pc;       o.rs1v = ex_rs1_val; o.rs2v = ex_rs2_val;
    o.imm = ex_imm;      o.rd = ex_rd;       o.rd_we = ex_rd_we;  o.alu = ex_alu_op;
    o.cls = ex_opclass;  o.ill = ex_illegal;
    return o;
  endfunction

  function automatic logic [31:0] model_bypass(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
    if (wb_we && wb_waddr == rs) return wb_wdata;
    return rf;
  endfunction

  // {uses_rs1, uses_rs2}
  function automatic logic [1:0] model_uses(input logic [31:0] inst);
    case (inst[6:0])
      7'h67, 7'h03, 7'h13: return 2'b10;
      7'h63, 7'h23, 7'h33: return 2'b11;
      default:             return 2'b00;
    endcase
  endfunction

  function automatic exp_t model_decode(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    logic [2:0] f3;
    f3 = inst[14:12];
    e = '0;
    e.valid = 1'b1;
    e.pc    = pc;
    e.rd    = inst[11:7];
    e.rs1v  = model_bypass(inst[19:15], rf_rdata1);
    e.rs2v  = model_bypass(inst[24:20], rf_rdata2);
    case (inst[6:0])
      7'h37, 7'h17: begin e.imm = inst & 32'hFFFFF000; e.cls = 4'b0001; e.rd_we = 1'b1; end
      7'h6F: begin
        e.imm = int'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        e.cls = 4'b1000; e.rd_we = 1'b1; e.alu = {1'b0, f3};
      end
      7'h67: begin
        e.imm = int'($signed(inst[31:20])); e.cls = 4'b1000; e.rd_we = 1'b1; e.alu = {1'b0, f3};
      end
      7'h63: begin
        e.imm = int'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        e.cls = 4'b1000; e.alu = {1'b0, f3};
      end
      7'h03: begin e.imm = int'($signed(inst[31:20])); e.cls = 4'b0010; e.rd_we = 1'b1; end
      7'h23: begin e.imm = int'($signed({inst[31:25], inst[11:7]})); e.cls = 4'b0100; end
      7'h13: begin
        e.imm = int'($signed(inst[31:20])); e.cls = 4'b0001; e.rd_we = 1'b1;
        e.alu = {(f3 == 3'd5) ? inst[30] : 1'b0, f3};
      end
      7'h33: begin e.imm = 32'd0; e.cls = 4'b0001; e.rd_we = 1'b1; e.alu = {inst[30], f3}; end
      default: e.ill = 1'b1;
    endcase
    if (e.rd == 5'd0) e.rd_we = 1'b0;
    return e;
  endfunction

  // Advance the reference model and the DUT by one clock; returns at the next negedge.
  task automatic cycle();
    logic       adv;
    logic       haz;
    logic [1:0] u;
    #1;
    rdy_obs = if_ready;
    u   = model_uses(if_inst);
    adv = !m.valid || ex_ready;
    haz = if_valid && m.valid && m.cls[1] && (m.rd != 5'd0) &&
          ((u[1] && if_inst[19:15] == m.rd) || (u[0] && if_inst[24:20] == m.rd));
    rdy_exp = flush || (adv && !haz);
    if (flush) m.valid = 1'b0;
    else if (adv) begin
      if (haz || !if_valid) m.valid = 1'b0;
      else m = model_decode(if_pc, if_inst);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] inst;
    int          idx;
    inst = $urandom;
    idx  = $urandom_range(0, 9);
    inst[6:0]   = (idx == 9) ? 7'($urandom) : ops[idx];
    inst[11:7]  = 5'($urandom_range(0, 3));
    inst[19:15] = 5'($urandom_range(0, 3));
    inst[24:20] = 5'($urandom_range(0, 3));
    return inst;
  endfunction

  task automatic test_reset();
    exp_t o;
    reset = 1'b0; flush = 1'b0; ex_ready = 1'b1; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    if_valid = 1'b1; if_inst = 32'h00500093; if_pc = 32'h100;
    rf_rdata1 = 32'h12345678; rf_rdata2 = 32'h9ABCDEF0;
    m = '0;
    repeat (2) @(negedge clk);
    o = observe();
    n_checks++;
    if (o !== '0) $display("FAIL reset_state: got %h want 0", o); else n_pass++;
    reset = 1'b1;
    cycle();
    n_checks++;
    if (rdy_obs !== 1'b1) $display("FAIL reset_if_ready: got %b want 1", rdy_obs); else n_pass++;
    n_checks++;
    if ({ex_valid, ex_rd, ex_rd_we, ex_imm, ex_alu_op, ex_opclass, ex_rs1_val} !==
        {1'b1, 5'd1, 1'b1, 32'd5, 4'b0000, 4'b0001, 32'd0})
      $display("FAIL reset_first_addi: got v=%b rd=%0d we=%b imm=%h alu=%b cls=%b rs1=%h want 1/1/1/5/0000/0001/0",
               ex_valid, ex_rd, ex_rd_we, ex_imm, ex_alu_op, ex_opclass, ex_rs1_val);
    else n_pass++;
  endtask

  task automatic test_load_use();
    ex_ready = 1'b1; if_valid = 1'b1; if_inst = 32'h0000A103; if_pc = 32'h200;
    cycle();
    n_checks++;
    if ({ex_valid, ex_opclass, ex_rd, ex_rd_we} !== {1'b1, 4'b0010, 5'd2, 1'b1})
      $display("FAIL lw_enter: got v=%b cls=%b rd=%0d we=%b want 1/0010/2/1", ex_valid, ex_opclass, ex_rd, ex_rd_we);
    else n_pass++;
    if_inst = 32'h001101B3; if_pc = 32'h204;
    cycle();
    n_checks++;
    if (rdy_obs !== 1'b0) $display("FAIL load_use_stall: if_ready got %b want 0", rdy_obs); else n_pass++;
    n_checks++;
    if (ex_valid !== 1'b0) $display("FAIL load_use_bubble: ex_valid got %b want 0", ex_valid); else n_pass++;
    cycle();
    n_checks++;
    if (rdy_obs !== 1'b1) $display("FAIL load_use_release: if_ready got %b want 1", rdy_obs); else n_pass++;
    n_checks++;
    if ({ex_valid, ex_rd, ex_pc, ex_alu_op} !== {1'b1, 5'd3, 32'h204, 4'b0000})
      $display("FAIL load_use_add: got v=%b rd=%0d pc=%h alu=%b want 1/3/204/0000", ex_valid, ex_rd, ex_pc, ex_alu_op);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    exp_t snap;
    exp_t o;
    ex_ready = 1'b0; if_valid = 1'b1; if_inst = 32'h00A00213; if_pc = 32'h208;
    snap = observe();
    for (int i = 0; i < 3; i++) begin
      cycle();
      o = observe();
      n_checks++;
      if (rdy_obs !== 1'b0) $display("FAIL bp_if_ready[%0d]: got %b want 0", i, rdy_obs); else n_pass++;
      n_checks++;
      if (o !== snap) $display("FAIL bp_hold[%0d]: got %h want %h", i, o, snap); else n_pass++;
    end
    ex_ready = 1'b1;
    cycle();
    n_checks++;
    if (rdy_obs !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", rdy_obs); else n_pass++;
    n_checks++;
    if ({ex_valid, ex_pc, ex_rd, ex_imm} !== {1'b1, 32'h208, 5'd4, 32'd10})
      $display("FAIL bp_release_enter: got v=%b pc=%h rd=%0d imm=%h want 1/208/4/a", ex_valid, ex_pc, ex_rd, ex_imm);
    else n_pass++;
  endtask

  task automatic test_flush();
    ex_ready = 1'b0; flush = 1'b1; if_valid = 1'b1; if_inst = 32'h00100093; if_pc = 32'h20C;
    cycle();
    n_checks++;
    if (rdy_obs !== 1'b1) $display("FAIL flush_if_ready: got %b want 1", rdy_obs); else n_pass++;
    n_checks++;
    if (ex_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", ex_valid); else n_pass++;
    flush = 1'b0; ex_ready = 1'b1; if_valid = 1'b0;
  endtask

  task automatic test_bypass();
    ex_ready = 1'b1; if_valid = 1'b1; if_inst = 32'h00728333; if_pc = 32'h300;
    rf_rdata1 = 32'h11111111; rf_rdata2 = 32'h33333333;
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hDEADBEEF;
    cycle();
    n_checks++;
    if ({rf_raddr1, rf_raddr2} !== {5'd5, 5'd7})
      $display("FAIL rf_raddr: got %0d,%0d want 5,7", rf_raddr1, rf_raddr2);
    else n_pass++;
    n_checks++;
    if ({ex_rs1_val, ex_rs2_val} !== {32'hDEADBEEF, 32'h33333333})
      $display("FAIL bypass_rs1: got %h,%h want deadbeef,33333333", ex_rs1_val, ex_rs2_val);
    else n_pass++;
    wb_waddr = 5'd7; wb_wdata = 32'hCAFEF00D;
    cycle();
    n_checks++;
    if ({ex_rs1_val, ex_rs2_val} !== {32'h11111111, 32'hCAFEF00D})
      $display("FAIL bypass_rs2: got %h,%h want 11111111,cafef00d", ex_rs1_val, ex_rs2_val);
    else n_pass++;
    if_inst = 32'h00700333; wb_waddr = 5'd0; rf_rdata1 = 32'h22222222;
    cycle();
    n_checks++;
    if (ex_rs1_val !== 32'd0) $display("FAIL bypass_x0: got %h want 0", ex_rs1_val); else n_pass++;
    wb_we = 1'b0; if_valid = 1'b0;
  endtask

  task automatic test_illegal_reset();
    ex_ready = 1'b1; if_valid = 1'b1; if_inst = 32'h0000007F; if_pc = 32'h400;
    cycle();
    n_checks++;
    if ({ex_valid, ex_illegal, ex_rd_we, ex_opclass} !== {1'b1, 1'b1, 1'b0, 4'b0000})
      $display("FAIL illegal_decode: got v=%b ill=%b we=%b cls=%b want 1/1/0/0000",
               ex_valid, ex_illegal, ex_rd_we, ex_opclass);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({ex_valid, ex_illegal} !== 2'b00)
      $display("FAIL async_reset: got v=%b ill=%b want 0/0", ex_valid, ex_illegal);
    else n_pass++;
    m = '0;
    if_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    exp_t o;
    logic prev_stall;
    prev_stall = 1'b0;
    for (int i = 0; i < 400; i++) begin
      flush    = ($urandom_range(0, 15) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      if (!prev_stall) begin
        if_valid = ($urandom_range(0, 4) != 0);
        if_inst  = rand_inst();
        if_pc    = $urandom & 32'hFFFFFFFC;
      end
      wb_we     = $urandom_range(0, 1) == 1;
      wb_waddr  = 5'($urandom_range(0, 3));
      wb_wdata  = $urandom;
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      cycle();
      prev_stall = if_valid && !rdy_exp;
      o = observe();
      n_checks++;
      if (rdy_obs !== rdy_exp) $display("FAIL rand_if_ready[%0d]: got %b want %b", i, rdy_obs, rdy_exp);
      else n_pass++;
      n_checks++;
      if (o.valid !== m.valid) $display("FAIL rand_valid[%0d]: got %b want %b", i, o.valid, m.valid);
      else n_pass++;
      if (m.valid) begin
        n_checks++;
        if (o !== m) $display("FAIL rand_fields[%0d]: got %h want %h", i, o, m);
        else n_pass++;
      end
    end
    flush = 1'b0; if_valid = 1'b0; wb_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_backpressure();
    test_flush();
    test_bypass();
    test_illegal_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
